mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter for the single port of the data RAM. It shares the port between the CPU load/store path and the UART debug/loader path, and returns read data to whichever requester issued each read. CPU accesses win by default. A starvation counter forces a one-cycle CPU stall so that a waiting debug request is always serviced. The block sits between MemOrIO/the UART programmer and the data RAM.

## Interface
Parameters:
- ADDR_W, 14, word-address width of the RAM.
- DATA_W, 32, data width.
- STARVE_LIMIT, 8, number of consecutive denied debug cycles before debug is forced through (legal range 1..255).

Ports:
- iCpuClock  in  1  sole clock, rising edge.
- iCpuResetN  in  1  asynchronous, active-low reset.
- iCpuReq  in  1  CPU access request, valid this cycle.
- iCpuWrite  in  1  1 = store, 0 = load.
- iCpuAddr  in  ADDR_W  CPU word address.
- iCpuWData  in  DATA_W  CPU store data.
- oCpuGrant  out  1  CPU access accepted this cycle (combinational).
- oCpuStall  out  1  CPU request denied this cycle (combinational); the CPU must hold its PC and request.
- oCpuRValid  out  1  CPU read data valid.
- oCpuRData  out  DATA_W  CPU read data.
- iDbgReq, iDbgWrite, iDbgAddr, iDbgWData  in  1/1/ADDR_W/DATA_W  debug-side request; the requester holds all four stable until granted.
- oDbgGrant  out  1  debug access accepted this cycle (combinational).
- oDbgRValid  out  1  debug read data valid.
- oDbgRData  out  DATA_W  debug read data.
- oRamWen  out  1  RAM write enable.
- oRamAddr  out  ADDR_W  RAM address.
- oRamWData  out  DATA_W  RAM write data.
- iRamRData  in  DATA_W  RAM read data; registered RAM with 1-cycle latency.
- oStarveEvent  out  1  one-cycle pulse each time a forced debug grant occurs.

## Operation
- FSM states:
  - S_NORMAL: CPU has priority.
  - S_FORCE: debug has priority.
- S_NORMAL decisions:
  - iCpuReq=1 → grant CPU. A simultaneous debug request is denied.
  - iCpuReq=0 and iDbgReq=1 → grant debug.
  - Both low → idle: oRamWen=0, and oRamAddr holds its last value.
- S_FORCE decisions:
  - iDbgReq=1 → grant debug. If iCpuReq=1 in the same cycle, oCpuStall=1.
  - iDbgReq=0 (request withdrawn) → behave as S_NORMAL.
  - Unconditional transition back to S_NORMAL after one cycle.
- Wait counter (8 bit, saturating at 255):
  - Increments each cycle with iDbgReq=1 and oDbgGrant=0.
  - Clears on any debug grant, or whenever iDbgReq=0.
  - Transition S_NORMAL → S_FORCE is registered: occurs when the incremented count equals STARVE_LIMIT.
  - oStarveEvent=1 during the S_FORCE cycle in which the debug grant happens.
- Port mux:
  - oRamAddr/oRamWData/oRamWen come combinationally from the granted requester.
  - oRamWen = grant & write.
- Read-return tag:
  - Registered 2-bit tag {cpu_rd, dbg_rd}, set in the grant cycle of a read.
  - Next cycle: the tagged side's RValid=1 and its RData=iRamRData. The other side's RData is 0.
  - Writes produce no RValid.
- Exactly one grant per cycle, never two. oCpuStall = iCpuReq & ~oCpuGrant.

## Timing
- Reset (async assert, sync release):
  - State S_NORMAL, counter 0, tag 00.
  - All registered outputs 0: oCpuRValid, oDbgRValid, oStarveEvent, oCpuRData, oDbgRData.
  - While iCpuResetN=0, oRamWen is forced to 0 and both grants are 0.
- Grant: same cycle as the request (combinational). Write commits at the next rising edge. Read data arrives 1 cycle after grant.
- Back-to-back reads are fully pipelined. A CPU read in cycle N and a debug read in cycle N+1 return in N+1 and N+2 respectively.
- Worst-case debug latency with the CPU requesting every cycle: STARVE_LIMIT+1 cycles from request to grant.
- Reset asserted mid-operation: a pending RValid is dropped, and an in-flight write of the current cycle is not committed.
- Stalled CPU request: the CPU retries the next cycle. The arbiter stores nothing.

## Test plan
- CPU only: write 0xDEADBEEF to addr 0x010, then read addr 0x010 → oCpuGrant=1 in both cycles, and oCpuRValid=1 with 0xDEADBEEF one cycle after the read grant.
- Idle CPU: debug write 0x12345678 to addr 0x3FFF, then debug read → oDbgGrant=1 immediately, and oDbgRData=0x12345678 one cycle later with oCpuRValid=0.
- Contention, STARVE_LIMIT=8: iCpuReq=1 continuously and iDbgReq=1 from cycle 0 → CPU granted in cycles 0–7, debug granted in cycle 8 with oCpuStall=1 and oStarveEvent=1, CPU granted again in cycle 9, counter cleared.
- Interleaved reads: CPU read 0x004 in cycle N, debug read 0x008 in cycle N+1 → oCpuRValid in N+1 and oDbgRValid in N+2, each carrying its own address's data, with no cross-delivery.
- Debug withdraws in S_FORCE (iDbgReq drops the cycle the FSM enters S_FORCE) → CPU granted, no stall, oStarveEvent=0, FSM returns to S_NORMAL.
- Async reset pulse mid-read (iCpuResetN low between clock edges after a grant) → RValid outputs go 0 immediately, no RValid after release, counter 0, first post-reset CPU request granted.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Request, response and RAM-port signals for the data-RAM port arbiter.
// slave = arbiter side; master = requesters plus RAM model side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic              iCpuReq;
  logic              iCpuWrite;
  logic [ADDR_W-1:0] iCpuAddr;
  logic [DATA_W-1:0] iCpuWData;
  logic              oCpuGrant;
  logic              oCpuStall;
  logic              oCpuRValid;
  logic [DATA_W-1:0] oCpuRData;

  logic              iDbgReq;
  logic              iDbgWrite;
  logic [ADDR_W-1:0] iDbgAddr;
  logic [DATA_W-1:0] iDbgWData;
  logic              oDbgGrant;
  logic              oDbgRValid;
  logic [DATA_W-1:0] oDbgRData;

  logic              oRamWen;
  logic [ADDR_W-1:0] oRamAddr;
  logic [DATA_W-1:0] oRamWData;
  logic [DATA_W-1:0] iRamRData;

  logic              oStarveEvent;

  modport slave (
    input  iCpuReq, iCpuWrite, iCpuAddr, iCpuWData,
    input  iDbgReq, iDbgWrite, iDbgAddr, iDbgWData,
    input  iRamRData,
    output oCpuGrant, oCpuStall, oCpuRValid, oCpuRData,
    output oDbgGrant, oDbgRValid, oDbgRData,
    output oRamWen, oRamAddr, oRamWData, oStarveEvent
  );

  modport master (
    output iCpuReq, iCpuWrite, iCpuAddr, iCpuWData,
    output iDbgReq, iDbgWrite, iDbgAddr, iDbgWData,
    output iRamRData,
    input  oCpuGrant, oCpuStall, oCpuRValid, oCpuRData,
    input  oDbgGrant, oDbgRValid, oDbgRData,
    input  oRamWen, oRamAddr, oRamWData, oStarveEvent
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// CPU/debug arbiter for the single data-RAM port: grant is combinational, read data returns 1 cycle later.
// CPU wins by default and is stalled (must retry) for one cycle when a starving debug request is forced through.
module mem_port_arbiter #(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                iCpuClock,
  input  logic                iCpuResetN,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic {
    S_NORMAL = 1'b0,
    S_FORCE  = 1'b1
  } state_e;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  state_e            state_q, state_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d, wait_cnt_inc;
  logic [1:0]        tag_q, tag_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              cpu_grant, dbg_grant, force_dbg;

  always_ff @(posedge iCpuClock or negedge iCpuResetN) begin
    if (!iCpuResetN) begin
      state_q    <= S_NORMAL;
      wait_cnt_q <= '0;
      tag_q      <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      tag_q      <= tag_d;
      addr_q     <= addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = '0;
    cpu_grant    = 1'b0;
    dbg_grant    = 1'b0;
    addr_d       = addr_q;
    wait_cnt_inc = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
    // A withdrawn debug request in S_FORCE falls back to normal CPU priority.
    force_dbg    = (state_q == S_FORCE) && bus.iDbgReq;

    if (iCpuResetN) begin
      dbg_grant = force_dbg || (!bus.iCpuReq && bus.iDbgReq);
      cpu_grant = bus.iCpuReq && !force_dbg;
    end

    if (bus.iDbgReq && !dbg_grant) begin
      wait_cnt_d = wait_cnt_inc;
    end

    case (state_q)
      S_NORMAL: begin
        if (bus.iDbgReq && !dbg_grant && (wait_cnt_inc == LIMIT)) begin
          state_d = S_FORCE;
        end
      end
      S_FORCE:  state_d = S_NORMAL;
      default:  state_d = S_NORMAL;
    endcase

    tag_d = {cpu_grant && !bus.iCpuWrite, dbg_grant && !bus.iDbgWrite};

    if (cpu_grant) begin
      addr_d = bus.iCpuAddr;
    end else if (dbg_grant) begin
      addr_d = bus.iDbgAddr;
    end
  end

  // Idle cycles keep the last address on the RAM port.
  assign bus.oRamAddr   = cpu_grant ? bus.iCpuAddr  : (dbg_grant ? bus.iDbgAddr  : addr_q);
  assign bus.oRamWData  = cpu_grant ? bus.iCpuWData : (dbg_grant ? bus.iDbgWData : '0);
  assign bus.oRamWen    = (cpu_grant && bus.iCpuWrite) || (dbg_grant && bus.iDbgWrite);

  assign bus.oCpuGrant    = cpu_grant;
  assign bus.oDbgGrant    = dbg_grant;
  assign bus.oCpuStall    = bus.iCpuReq && !cpu_grant;
  assign bus.oStarveEvent = (state_q == S_FORCE) && dbg_grant;

  assign bus.oCpuRValid = tag_q[1];
  assign bus.oDbgRValid = tag_q[0];
  assign bus.oCpuRData  = tag_q[1] ? bus.iRamRData : '0;
  assign bus.oDbgRData  = tag_q[0] ? bus.iRamRData : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a registered single-port RAM model.
module tb_mem_port_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [31:0] mem [0:16383];

  mem_port_arbiter_if #(.ADDR_W(14), .DATA_W(32)) bus();

  mem_port_arbiter #(
    .ADDR_W(14),
    .DATA_W(32),
    .STARVE_LIMIT(8)
  ) dut (
    .iCpuClock (clk),
    .iCpuResetN(rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.oRamWen) mem[bus.oRamAddr] <= bus.oRamWData;
    bus.iRamRData <= mem[bus.oRamAddr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic cr, input logic cw, input logic [13:0] ca, input logic [31:0] cd,
                        input logic dr, input logic dw, input logic [13:0] da, input logic [31:0] dd);
    bus.iCpuReq   = cr;
    bus.iCpuWrite = cw;
    bus.iCpuAddr  = ca;
    bus.iCpuWData = cd;
    bus.iDbgReq   = dr;
    bus.iDbgWrite = dw;
    bus.iDbgAddr  = da;
    bus.iDbgWData = dd;
    #1;
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0, 14'h0, 32'h0);
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    bus.iRamRData = 32'h0;
    rst_n = 1'b0;

    // Reset state, with a CPU write attempted during reset.
    set_in(1'b1, 1'b1, 14'h010, 32'hCAFE_0000, 1'b1, 1'b1, 14'h011, 32'hCAFE_0001);
    check("rst_cpu_grant", 32'(bus.oCpuGrant), 32'd0);
    check("rst_dbg_grant", 32'(bus.oDbgGrant), 32'd0);
    check("rst_wen", 32'(bus.oRamWen), 32'd0);
    check("rst_cpu_rvalid", 32'(bus.oCpuRValid), 32'd0);
    check("rst_dbg_rvalid", 32'(bus.oDbgRValid), 32'd0);
    check("rst_cpu_rdata", bus.oCpuRData, 32'd0);
    check("rst_dbg_rdata", bus.oDbgRData, 32'd0);
    check("rst_event", 32'(bus.oStarveEvent), 32'd0);
    next();
    next();
    rst_n = 1'b1;

    // CPU only: write then read.
    set_in(1'b1, 1'b1, 14'h010, 32'hDEAD_BEEF, 1'b0, 1'b0, 14'h0, 32'h0);
    check("cpuw_grant", 32'(bus.oCpuGrant), 32'd1);
    check("cpuw_wen", 32'(bus.oRamWen), 32'd1);
    check("cpuw_addr", 32'(bus.oRamAddr), 32'h010);
    check("cpuw_wdata", bus.oRamWData, 32'hDEAD_BEEF);
    check("cpuw_stall", 32'(bus.oCpuStall), 32'd0);
    next();
    set_in(1'b1, 1'b0, 14'h010, 32'h0, 1'b0, 1'b0, 14'h0, 32'h0);
    check("cpur_grant", 32'(bus.oCpuGrant), 32'd1);
    check("cpur_wen", 32'(bus.oRamWen), 32'd0);
    check("cpuw_no_rvalid", 32'(bus.oCpuRValid), 32'd0);
    next();
    idle();
    check("cpur_rvalid", 32'(bus.oCpuRValid), 32'd1);
    check("cpur_rdata", bus.oCpuRData, 32'hDEAD_BEEF);
    check("cpur_dbg_rvalid", 32'(bus.oDbgRValid), 32'd0);
    check("cpur_dbg_rdata", bus.oDbgRData, 32'd0);
    check("idle_wen", 32'(bus.oRamWen), 32'd0);
    check("idle_addr_hold", 32'(bus.oRamAddr), 32'h010);
    next();

    // Idle CPU: debug write then read at the top address.
    set_in(1'b0, 1'b0, 14'h0, 32'h0, 1'b1, 1'b1, 14'h3FFF, 32'h1234_5678);
    check("dbgw_grant", 32'(bus.oDbgGrant), 32'd1);
    check("dbgw_wen", 32'(bus.oRamWen), 32'd1);
    check("dbgw_addr", 32'(bus.oRamAddr), 32'h3FFF);
    check("dbgw_event", 32'(bus.oStarveEvent), 32'd0);
    next();
    set_in(1'b0, 1'b0, 14'h0, 32'h0, 1'b1, 1'b0, 14'h3FFF, 32'h0);
    check("dbgr_grant", 32'(bus.oDbgGrant), 32'd1);
    check("dbgr_wen", 32'(bus.oRamWen), 32'd0);
    next();
    idle();
    check("dbgr_rvalid", 32'(bus.oDbgRValid), 32'd1);
    check("dbgr_rdata", bus.oDbgRData, 32'h1234_5678);
    check("dbgr_cpu_rvalid", 32'(bus.oCpuRValid), 32'd0);
    check("dbgr_cpu_rdata", bus.oCpuRData, 32'd0);
    next();

    // Preload data for later reads.
    set_in(1'b1, 1'b1, 14'h004, 32'hA5A5_0004, 1'b0, 1'b0, 14'h0, 32'h0);
    next();
    set_in(1'b1, 1'b1, 14'h008, 32'h5A5A_0008, 1'b0, 1'b0, 14'h0, 32'h0);
    next();

    // Contention: CPU every cycle, debug from cycle 0.
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, 1'b0, 14'h004, 32'h0, 1'b1, 1'b0, 14'h008, 32'h0);
      check("cont_cpu_grant", 32'(bus.oCpuGrant), 32'd1);
      check("cont_dbg_denied", 32'(bus.oDbgGrant), 32'd0);
      check("cont_no_event", 32'(bus.oStarveEvent), 32'd0);
      next();
    end
    set_in(1'b1, 1'b0, 14'h004, 32'h0, 1'b1, 1'b0, 14'h008, 32'h0);
    check("force_dbg_grant", 32'(bus.oDbgGrant), 32'd1);
    check("force_cpu_grant", 32'(bus.oCpuGrant), 32'd0);
    check("force_stall", 32'(bus.oCpuStall), 32'd1);
    check("force_event", 32'(bus.oStarveEvent), 32'd1);
    check("force_addr", 32'(bus.oRamAddr), 32'h008);
    next();
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, 1'b0, 14'h004, 32'h0, 1'b1, 1'b0, 14'h008, 32'h0);
      check("after_cpu_grant", 32'(bus.oCpuGrant), 32'd1);
      if (i == 0) begin
        check("force_dbg_rvalid", 32'(bus.oDbgRValid), 32'd1);
        check("force_dbg_rdata", bus.oDbgRData, 32'h5A5A_0008);
        check("force_cpu_rvalid", 32'(bus.oCpuRValid), 32'd0);
      end
      next();
    end
    set_in(1'b1, 1'b0, 14'h004, 32'h0, 1'b1, 1'b0, 14'h008, 32'h0);
    check("force2_dbg_grant", 32'(bus.oDbgGrant), 32'd1);
    check("force2_event", 32'(bus.oStarveEvent), 32'd1);
    next();

    // Interleaved reads: CPU in N, debug in N+1.
    set_in(1'b1, 1'b0, 14'h004, 32'h0, 1'b0, 1'b0, 14'h0, 32'h0);
    check("il_cpu_grant", 32'(bus.oCpuGrant), 32'd1);
    next();
    set_in(1'b0, 1'b0, 14'h0, 32'h0, 1'b1, 1'b0, 14'h008, 32'h0);
    check("il_dbg_grant", 32'(bus.oDbgGrant), 32'd1);
    check("il_cpu_rvalid", 32'(bus.oCpuRValid), 32'd1);
    check("il_cpu_rdata", bus.oCpuRData, 32'hA5A5_0004);
    check("il_dbg_rvalid0", 32'(bus.oDbgRValid), 32'd0);
    check("il_dbg_rdata0", bus.oDbgRData, 32'd0);
    next();
    idle();
    check("il_dbg_rvalid", 32'(bus.oDbgRValid), 32'd1);
    check("il_dbg_rdata", bus.oDbgRData, 32'h5A5A_0008);
    check("il_cpu_rvalid0", 32'(bus.oCpuRValid), 32'd0);
    check("il_cpu_rdata0", bus.oCpuRData, 32'd0);
    next();

    // Debug withdraws the cycle the FSM enters S_FORCE.
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, 1'b0, 14'h004, 32'h0, 1'b1, 1'b0, 14'h008, 32'h0);
      next();
    end
    set_in(1'b1, 1'b0, 14'h004, 32'h0, 1'b0, 1'b0, 14'h008, 32'h0);
    check("wd_cpu_grant", 32'(bus.oCpuGrant), 32'd1);
    check("wd_stall", 32'(bus.oCpuStall), 32'd0);
    check("wd_event", 32'(bus.oStarveEvent), 32'd0);
    check("wd_dbg_grant", 32'(bus.oDbgGrant), 32'd0);
    next();
    set_in(1'b1, 1'b0, 14'h004, 32'h0, 1'b1, 1'b0, 14'h008, 32'h0);
    check("wd_normal_cpu", 32'(bus.oCpuGrant), 32'd1);
    check("wd_normal_dbg", 32'(bus.oDbgGrant), 32'd0);
    next();

    // Async reset mid-read, with the wait counter non-zero.
    set_in(1'b1, 1'b0, 14'h004, 32'h0, 1'b1, 1'b0, 14'h008, 32'h0);
    next();
    set_in(1'b1, 1'b0, 14'h004, 32'h0, 1'b1, 1'b0, 14'h008, 32'h0);
    next();
    idle();
    check("pre_rst_rvalid", 32'(bus.oCpuRValid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rvalid", 32'(bus.oCpuRValid), 32'd0);
    check("mid_rst_rdata", bus.oCpuRData, 32'd0);
    set_in(1'b1, 1'b1, 14'h004, 32'hFFFF_FFFF, 1'b0, 1'b0, 14'h0, 32'h0);
    check("mid_rst_wen", 32'(bus.oRamWen), 32'd0);
    check("mid_rst_grant", 32'(bus.oCpuGrant), 32'd0);
    next();
    rst_n = 1'b1;
    idle();
    check("post_rst_rvalid", 32'(bus.oCpuRValid), 32'd0);
    next();
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, 1'b0, 14'h004, 32'h0, 1'b1, 1'b0, 14'h008, 32'h0);
      check("post_rst_cpu_grant", 32'(bus.oCpuGrant), 32'd1);
      if (i == 1) begin
        check("post_rst_rdata", bus.oCpuRData, 32'hA5A5_0004);
      end
      next();
    end
    set_in(1'b1, 1'b0, 14'h004, 32'h0, 1'b1, 1'b0, 14'h008, 32'h0);
    check("post_rst_force", 32'(bus.oDbgGrant), 32'd1);
    next();
    idle();
    next();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
